// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC and issues word requests to
// instruction memory over a req/ack handshake. Delivers {inst, pc+4} to IF/ID
// through an output slot backed by a one-entry skid buffer, and discards
// wrong-path data on redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ALIGN_W = 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic [XLEN-1:0] next_pc, next_pc_n;
  logic [XLEN-1:0] drop_addr, drop_addr_n;
  logic            valid_n;
  logic [XLEN-1:0] inst_n, pc_n;
  logic            sk_valid, sk_valid_n;
  logic [XLEN-1:0] sk_inst, sk_inst_n;
  logic [XLEN-1:0] sk_pc, sk_pc_n;
  logic            req_n;
  logic [XLEN-1:0] addr_n;

  logic            mem_ack;
  logic            consume;
  logic            word_in;
  logic [XLEN-1:0] target;
  logic            unused_pc_bits;

  // Ack only counts while a request is actually being presented.
  assign mem_ack = imem_req_o & imem_ack_i;
  // IF/ID takes the output slot this cycle.
  assign consume = valid_o & ~stall_i;
  // A correct-path word returns this cycle.
  assign word_in = (state_q == REQ) & mem_ack & ~redirect_i;
  // Redirect target forced to word alignment.
  assign target  = {redirect_pc_i[XLEN-1:ALIGN_W], ALIGN_W'(0)};
  assign unused_pc_bits = ^redirect_pc_i[ALIGN_W-1:0];

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state: pause fetching whenever the skid buffer will be occupied.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (!sk_valid_n) state_n = REQ;
      end
      REQ: begin
        if (redirect_i) begin
          state_n = mem_ack ? REQ : DROP;
        end else if (mem_ack && sk_valid_n) begin
          state_n = IDLE;
        end
      end
      DROP: begin
        if (mem_ack) state_n = sk_valid_n ? IDLE : REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath next values: slot/skid movement, PC advance, redirect flush.
  always_comb begin
    valid_n     = valid_o;
    inst_n      = inst_o;
    pc_n        = pc_o;
    sk_valid_n  = sk_valid;
    sk_inst_n   = sk_inst;
    sk_pc_n     = sk_pc;
    next_pc_n   = next_pc;
    drop_addr_n = drop_addr;
    if (redirect_i) begin
      valid_n    = 1'b0;
      sk_valid_n = 1'b0;
      next_pc_n  = target;
      if (state_q == REQ && !mem_ack) drop_addr_n = next_pc;
    end else begin
      if (consume) begin
        valid_n = 1'b0;
        if (sk_valid) begin
          valid_n    = 1'b1;
          inst_n     = sk_inst;
          pc_n       = sk_pc;
          sk_valid_n = 1'b0;
        end
      end
      if (word_in) begin
        next_pc_n = next_pc + PC_STEP;
        if (!valid_n) begin
          valid_n = 1'b1;
          inst_n  = imem_data_i;
          pc_n    = next_pc_n;
        end else begin
          sk_valid_n = 1'b1;
          sk_inst_n  = imem_data_i;
          sk_pc_n    = next_pc_n;
        end
      end
    end
  end

  // Output decode: request level and address for the coming cycle.
  always_comb begin
    req_n  = (state_n != IDLE);
    addr_n = (state_n == DROP) ? drop_addr_n : next_pc_n;
  end

  // Datapath and memory-interface registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      next_pc     <= RESET_PC;
      drop_addr   <= RESET_PC;
      valid_o     <= 1'b0;
      inst_o      <= '0;
      pc_o        <= '0;
      sk_valid    <= 1'b0;
      sk_inst     <= '0;
      sk_pc       <= '0;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
    end else begin
      next_pc     <= next_pc_n;
      drop_addr   <= drop_addr_n;
      valid_o     <= valid_n;
      inst_o      <= inst_n;
      pc_o        <= pc_n;
      sk_valid    <= sk_valid_n;
      sk_inst     <= sk_inst_n;
      sk_pc       <= sk_pc_n;
      imem_req_o  <= req_n;
      imem_addr_o <= addr_n;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus a randomized stall/redirect/
// latency phase, all checked against an in-order expected-PC stream.
module tb_if_fetch;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        stall, redir;
  logic [31:0] redir_pc;
  logic        req, ack;
  logic [31:0] addr, rdata;
  logic        valid;
  logic [31:0] inst, pc;

  logic        w_stall, w_redir;
  logic [31:0] w_rpc;
  logic        w_req, w_ack;
  logic [31:0] w_addr, w_rdata;
  logic        w_valid;
  logic [31:0] w_inst, w_pc;

  int          nerr;
  int          nchk;
  int          lat_mode;
  int          mem_cnt;
  int          mem_lat;
  int          ndeliv;
  logic [31:0] exp_pc;
  logic        blank;
  logic        prev_pend;
  logic [31:0] prev_addr;
  logic [31:0] p0;

  if_fetch u_dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redir),
    .redirect_pc_i(redir_pc), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_data_i(rdata), .valid_o(valid),
    .inst_o(inst), .pc_o(pc)
  );

  if_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk_i(clk), .rst_i(rst), .stall_i(w_stall), .redirect_i(w_redir),
    .redirect_pc_i(w_rpc), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ack_i(w_ack), .imem_data_i(w_rdata), .valid_o(w_valid),
    .inst_o(w_inst), .pc_o(w_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, answer memory, check outputs, advance the model.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
    stall    = st;
    redir    = rd;
    redir_pc = rpc;
    ack      = 1'b0;
    if (req) begin
      if (mem_cnt == 0) mem_lat = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        ack     = 1'b1;
        mem_cnt = 0;
      end
    end
    rdata   = ack ? mem_word(addr) : $urandom;
    w_ack   = w_req;
    w_rdata = w_req ? mem_word(w_addr) : 32'h0;

    if (blank) chk("blank_after_redirect", {31'd0, valid}, 32'd0);
    if (valid) begin
      chk("stream_pc", pc, exp_pc);
      chk("stream_inst", inst, mem_word(exp_pc - 32'd4));
    end
    if (prev_pend) begin
      chk("req_held", {31'd0, req}, 32'd1);
      chk("addr_stable", addr, prev_addr);
    end

    prev_pend = req & ~ack;
    prev_addr = addr;
    if (valid && !st && !rd) begin
      exp_pc = exp_pc + 32'd4;
      ndeliv++;
    end
    if (rd) exp_pc = {rpc[31:2], 2'b00} + 32'd4;
    blank = rd;
    @(posedge clk);
    #1;
  endtask

  // One-cycle synchronous reset, then check reset values.
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = '0;
    ack = 1'b0; rdata = '0; w_ack = 1'b0; w_rdata = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_cnt = 0; exp_pc = 32'd4; blank = 1'b0; prev_pend = 1'b0;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wrap_addr", w_addr, WRAP_PC);
    chk("rst_wrap_valid", {31'd0, w_valid}, 32'd0);
  endtask

  // Zero-wait start-up: IDLE cycle, first request, then one word per clock.
  task automatic post_reset_seq();
    chk("idle_req", {31'd0, req}, 32'd0);
    chk("wrap_idle_req", {31'd0, w_req}, 32'd0);
    cycle(1'b0, 1'b0, '0);
    chk("first_req", {31'd0, req}, 32'd1);
    chk("first_addr", addr, 32'd0);
    chk("wrap_first_addr", w_addr, WRAP_PC);
    cycle(1'b0, 1'b0, '0);
    for (int c = 3; c <= 10; c++) begin
      chk("tput_valid", {31'd0, valid}, 32'd1);
      chk("tput_pc", pc, 32'(4 * (c - 2)));
      if (c <= 5) begin
        chk("wrap_valid", {31'd0, w_valid}, 32'd1);
        chk("wrap_pc", w_pc, WRAP_PC + 32'(4 * (c - 2)));
      end
      cycle(1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    nerr = 0; nchk = 0; ndeliv = 0; mem_lat = 1; mem_cnt = 0;
    w_stall = 1'b0; w_redir = 1'b0; w_rpc = '0;
    lat_mode = 1;
    #1;
    do_reset();
    post_reset_seq();

    // Stall for 5 cycles mid-stream.
    p0 = pc;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold_pc", pc, p0);
      if (i >= 1) chk("stall_req_low", {31'd0, req}, 32'd0);
      cycle(1'b1, 1'b0, '0);
    end
    for (int i = 0; i < 3; i++) begin
      chk("release_valid", {31'd0, valid}, 32'd1);
      chk("release_pc", pc, p0 + 32'(4 * i));
      cycle(1'b0, 1'b0, '0);
    end

    // Three-cycle memory latency: one delivery every third cycle.
    lat_mode = 3;
    repeat (4) cycle(1'b0, 1'b0, '0);
    for (int k = 0; k < 8 && !valid; k++) cycle(1'b0, 1'b0, '0);
    chk("lat3_found", {31'd0, valid}, 32'd1);
    for (int k = 0; k < 9; k++) begin
      chk("lat3_pattern", {31'd0, valid}, (k % 3 == 0) ? 32'd1 : 32'd0);
      cycle(1'b0, 1'b0, '0);
    end

    // Redirect while a request is outstanding.
    for (int k = 0; k < 10 && !(req && mem_cnt == 0); k++) cycle(1'b0, 1'b0, '0);
    chk("redir_setup", {31'd0, req && mem_cnt == 0}, 32'd1);
    cycle(1'b0, 1'b1, 32'h0000_0103);
    for (int k = 0; k < 12 && !valid; k++) cycle(1'b0, 1'b0, '0);
    chk("redir_valid", {31'd0, valid}, 32'd1);
    chk("redir_pc", pc, 32'h0000_0104);
    chk("redir_inst", inst, mem_word(32'h0000_0100));
    cycle(1'b0, 1'b0, '0);

    // Redirect coinciding with an ack while stalled.
    lat_mode = 1;
    repeat (3) cycle(1'b0, 1'b0, '0);
    for (int k = 0; k < 6 && !(valid && req); k++) cycle(1'b0, 1'b0, '0);
    chk("co_setup", {31'd0, valid && req}, 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    chk("co_blank", {31'd0, valid}, 32'd0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("co_req_low", {31'd0, req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("co_valid", {31'd0, valid}, 32'd1);
      chk("co_pc", pc, 32'h0000_0204 + 32'(4 * i));
      cycle(1'b0, 1'b0, '0);
    end

    // Randomized latency, stall and redirect traffic.
    lat_mode = 0;
    ndeliv = 0;
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, $urandom);
    end
    chk("random_progress", {31'd0, ndeliv > 40}, 32'd1);

    // Mid-stream reset and restart.
    lat_mode = 1;
    repeat (3) cycle(1'b0, 1'b0, '0);
    do_reset();
    post_reset_seq();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage pipeline: owns the fetch PC, issues word requests to instruction memory over a req/ack handshake, and presents fetched instructions with their PC+4 to the IF/ID pipeline register. It tolerates variable memory latency, honours the decode-stage hazard stall through a one-entry skid buffer, and discards wrong-path fetches on a branch/jump redirect.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; one clock, synchronous, active-high
- stall_i  in  1  hazard stall from decode; IF/ID is not accepting this cycle
- redirect_i  in  1  branch taken / jump resolved; same cycle IF/ID is flushed
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (treated as 00)
- imem_req_o  out  1  instruction memory request, level, held until ack
- imem_addr_o  out  32  request word address; stable while req high and ack low
- imem_ack_i  in  1  request complete; imem_data_i valid this cycle; only meaningful while req high
- imem_data_i  in  32  fetched instruction word
- valid_o  out  1  inst_o/pc_o hold an instruction for IF/ID
- inst_o  out  32  instruction to IF/ID
- pc_o  out  32  fetch address + 4 to IF/ID

## Operation
- Registers: next_pc (next fetch address), drop_addr, output slot (valid_o/inst_o/pc_o), skid slot (sk_valid/sk_inst/sk_pc), state in {IDLE, REQ, DROP}.
- Consume: output slot drained when valid_o=1 and stall_i=0. Skid moves to output slot on consume (same edge).
- IDLE: req=0. Go REQ when skid empty (no redirect needed).
- REQ: req=1, addr=next_pc. On ack: next_pc <= next_pc+4; word (inst=imem_data_i, pc=addr+4) goes to output slot if free or consumed this cycle, else to skid. If skid is full after this edge -> IDLE, else stay REQ (back-to-back fetch).
- DROP: req=1, addr=drop_addr (old in-flight address). On ack: data discarded; -> REQ if skid empty, else IDLE.
- Redirect (priority over stall and ack data): clears valid_o and sk_valid; next_pc <= {redirect_pc_i[31:2],2'b00}.
  - REQ, no ack same cycle: drop_addr <= next_pc, -> DROP.
  - REQ, ack same cycle: returned word discarded, stay REQ (requests target next cycle).
  - DROP: target replaces next_pc, remain DROP until ack.
  - IDLE: -> REQ next cycle.
- Arithmetic: PC increments mod 2^32; 32'hFFFF_FFFC + 4 = 0. Low two address bits always 00.
- Never issues a request when skid is full; at most one request outstanding.

## Timing
- Reset values: valid_o=0, inst_o=0 (NOP), pc_o=0, imem_req_o=0, imem_addr_o=RESET_PC, sk_valid=0, state IDLE, next_pc=RESET_PC.
- Reset mid-operation: everything returns to reset values next edge; any in-flight memory transaction is abandoned (instruction memory is reset by the same rst_i).
- First request: first cycle after rst_i deasserts goes IDLE->REQ; req high the following cycle.
- Zero-wait memory (ack same cycle as req): ack edge loads output slot; valid_o next cycle; sustained throughput one instruction per clock with stall_i=0.
- stall_i high for N cycles: output slot holds value; at most one extra word lands in skid; fetch pauses; on release, output and skid drain on consecutive cycles, refetch resumes with no lost or duplicated PC.
- Redirect: valid_o low the cycle after redirect; first target instruction valid_o earliest 2 cycles after redirect with zero-wait memory (1 req cycle + output register); with an outstanding request, additionally the remaining latency of the dropped access.

## Test plan
- Reset, RESET_PC=0, zero-wait memory, stall_i=0 -> req high from cycle 2; valid_o stream pc_o=4,8,12,... with inst_o = mem[0],mem[1],... one per cycle.
- 3-cycle memory latency -> imem_addr_o stable across wait; valid_o one pulse per 3 cycles; pc_o increments by 4 each delivery.
- stall_i high 5 cycles mid-stream -> inst_o/pc_o frozen, imem_req_o low after skid fills; release yields next two PCs back-to-back, no gaps/duplicates.
- redirect_i with redirect_pc_i=32'h0000_0103 while request outstanding (latency 3) -> stale word discarded, valid_o=0 until target; next delivered pc_o=32'h0000_0104, inst_o=mem[0x100>>2].
- redirect_i coincident with ack and stall_i=1 -> no stale word appears in output or skid; next delivery is target.
- RESET_PC=32'hFFFF_FFF8 -> delivers pc_o=32'hFFFF_FFFC, 0, 4; mid-stream rst_i pulse -> next cycle valid_o=0, imem_req_o=0, restart at RESET_PC.
